// File: rtl/smart_led_pkg.sv
// Shared types and helpers for the smart LED array.
//   ch_state_e  : per-channel occupancy state
//   MODE_*      : per-channel mode encodings (2'b11 decodes as AUTO)
//   calc_presc  : clocks per PWM count step, never below 1
package smart_led_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } ch_state_e;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_AUTO  = 2'b01;
  localparam logic [1:0] MODE_FORCE = 2'b10;

  // CLK_FREQ / (PWM_FREQ * 2^SENSOR_W), clamped to at least 1
  function automatic int unsigned calc_presc(input int unsigned clk_freq,
                                             input int unsigned pwm_freq,
                                             input int unsigned sensor_w);
    longint unsigned denom;
    longint unsigned q;
    denom = 64'(pwm_freq) << sensor_w;
    if (denom == 64'd0) return 32'd1;
    q = 64'(clk_freq) / denom;
    return (q < 64'd1) ? 32'd1 : 32'(q);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: motion synchronizer, occupancy FSM with hold-off timer,
// target selection, linear fade and PWM compare.
//   clk, rst   : clock, async active-low reset
//   motion     : raw (asynchronous) motion input
//   mode       : 00 OFF, 01/11 AUTO, 10 FORCE_ON
//   wrap       : one-cycle strobe at the end of every PWM period
//   pwm_cnt    : shared PWM counter
//   light      : latched ambient light sample
//   dark       : latched hysteretic dark flag
//   led_on     : registered, level is nonzero
//   pwm_led    : registered PWM output
module led_channel
  import smart_led_pkg::*;
#(
  parameter int unsigned SENSOR_W     = 10,
  parameter int unsigned HOLD_PERIODS = 1000,
  parameter int unsigned FADE_STEP    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                motion,
  input  logic [1:0]          mode,
  input  logic                wrap,
  input  logic [SENSOR_W-1:0] pwm_cnt,
  input  logic [SENSOR_W-1:0] light,
  input  logic                dark,
  output logic                led_on,
  output logic                pwm_led
);

  localparam int unsigned LW     = SENSOR_W + 1;
  localparam int unsigned MAX_I  = (32'd1 << SENSOR_W) - 32'd1;
  // A step at or above MAX always snaps, so clamping keeps it representable
  localparam int unsigned STEP_I = (FADE_STEP > MAX_I) ? MAX_I : FADE_STEP;
  localparam int unsigned HOLD_W = (HOLD_PERIODS > 0) ? $clog2(HOLD_PERIODS + 1) : 1;

  localparam logic [SENSOR_W-1:0] MAX       = '1;
  localparam logic [LW-1:0]       STEP      = LW'(STEP_I);
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_PERIODS);

  logic                sync_q, mot_s_q;
  ch_state_e           state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SENSOR_W-1:0] level_q, level_d;
  logic                led_on_q, led_on_d;
  logic                pwm_led_q, pwm_led_d;
  logic [SENSOR_W-1:0] target;
  logic [LW-1:0]       lvl_x, tgt_x;
  logic                mode_off, mode_auto, mode_force;

  assign mode_off   = (mode == MODE_OFF);
  assign mode_force = (mode == MODE_FORCE);
  assign mode_auto  = (mode == MODE_AUTO) || (mode == 2'b11);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and hold counter; mode OFF overrides every transition
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (mode_off) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (mot_s_q) state_d = ACTIVE;
        ACTIVE: begin
          if (!mot_s_q) begin
            if (HOLD_PERIODS == 0) begin
              state_d = IDLE;
            end else begin
              state_d = HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          // Motion wins over an expiry in the same cycle
          if (mot_s_q) begin
            state_d = ACTIVE;
          end else if (wrap) begin
            if (hold_q <= HOLD_W'(1)) begin
              state_d = IDLE;
              hold_d  = '0;
            end else begin
              hold_d = hold_q - HOLD_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM output: brightness target
  always_comb begin
    target = '0;
    if (mode_force) target = MAX;
    else if (mode_auto && (state_q != IDLE) && dark) target = MAX - light;
  end

  // Fade toward target on wrap; widened by one bit so steps never wrap
  always_comb begin
    lvl_x   = {1'b0, level_q};
    tgt_x   = {1'b0, target};
    level_d = level_q;
    if (mode_off) begin
      level_d = '0;
    end else if (wrap) begin
      if (tgt_x >= lvl_x) level_d = ((tgt_x - lvl_x) <= STEP) ? target : SENSOR_W'(lvl_x + STEP);
      else                level_d = ((lvl_x - tgt_x) <= STEP) ? target : SENSOR_W'(lvl_x - STEP);
    end
  end

  // Output compare
  always_comb begin
    pwm_led_d = (pwm_cnt < level_q);
    led_on_d  = (level_q != '0);
  end

  // Synchronizer, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 1'b0;
      mot_s_q   <= 1'b0;
      hold_q    <= '0;
      level_q   <= '0;
      led_on_q  <= 1'b0;
      pwm_led_q <= 1'b0;
    end else begin
      sync_q    <= motion;
      mot_s_q   <= sync_q;
      hold_q    <= hold_d;
      level_q   <= level_d;
      led_on_q  <= led_on_d;
      pwm_led_q <= pwm_led_d;
    end
  end

  assign led_on  = led_on_q;
  assign pwm_led = pwm_led_q;

endmodule

// File: rtl/smart_led_array.sv
// Multi-channel smart LED controller: shared prescaler, PWM counter and
// hysteretic ambient-light sampling feeding NUM_CH independent channels.
//   clk, rst      : clock, async active-low reset
//   motion        : per-channel motion, asynchronous
//   light_sensor  : ambient light sample (larger is brighter)
//   mode          : 2 bits per channel, channel i at [2i+1:2i]
//   led_on        : per-channel level nonzero (registered)
//   pwm_led       : per-channel PWM (registered)
module smart_led_array
  import smart_led_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned PWM_FREQ     = 1000,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SENSOR_W     = 10,
  parameter int unsigned DARK_TH      = 300,
  parameter int unsigned BRIGHT_TH    = 600,
  parameter int unsigned HOLD_PERIODS = 1000,
  parameter int unsigned FADE_STEP    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     motion,
  input  logic [SENSOR_W-1:0]   light_sensor,
  input  logic [2*NUM_CH-1:0]   mode,
  output logic [NUM_CH-1:0]     led_on,
  output logic [NUM_CH-1:0]     pwm_led
);

  localparam int unsigned PRESC   = calc_presc(CLK_FREQ, PWM_FREQ, SENSOR_W);
  localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned LW      = SENSOR_W + 1;

  localparam logic [SENSOR_W-1:0] MAX      = '1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESC - 1);
  localparam logic [LW-1:0]       DARK_X   = LW'(DARK_TH);
  localparam logic [LW-1:0]       BRIGHT_X = LW'(BRIGHT_TH);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [SENSOR_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SENSOR_W-1:0] light_q, light_d;
  logic                dark_q, dark_d;
  logic                tick, wrap;

  assign tick = (presc_q == PRESC_LAST);
  assign wrap = tick && (pwm_cnt_q == MAX);

  // Prescaler, PWM counter and light sample with dark hysteresis
  always_comb begin
    presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + SENSOR_W'(1) : pwm_cnt_q;
    light_d   = light_q;
    dark_d    = dark_q;
    if (wrap) begin
      light_d = light_sensor;
      if ({1'b0, light_sensor} < DARK_X)        dark_d = 1'b1;
      else if ({1'b0, light_sensor} > BRIGHT_X) dark_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      light_q   <= '0;
      dark_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      light_q   <= light_d;
      dark_q    <= dark_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .SENSOR_W    (SENSOR_W),
      .HOLD_PERIODS(HOLD_PERIODS),
      .FADE_STEP   (FADE_STEP)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .motion (motion[i]),
      .mode   (mode[2*i +: 2]),
      .wrap   (wrap),
      .pwm_cnt(pwm_cnt_q),
      .light  (light_q),
      .dark   (dark_q),
      .led_on (led_on[i]),
      .pwm_led(pwm_led[i])
    );
  end

endmodule

// File: tb/tb_smart_led_array.sv
// Directed bench for smart_led_array. PRESC=1, so one PWM period is 1024
// clocks; edge_cnt mirrors the expected pwm_cnt phase from reset release.
// Period Pk is the 1024-clock window following the k-th wrap; each entry in
// the tables is the expected high count of pwm_led in that window.
module tb_smart_led_array;

  localparam int unsigned PERIOD = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] motion;
  logic [9:0] light_sensor;
  logic [3:0] mode;
  logic [1:0] led_on;
  logic [1:0] pwm_led;

  int unsigned edge_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  smart_led_array #(
    .CLK_FREQ    (1_024_000),
    .PWM_FREQ    (1000),
    .NUM_CH      (2),
    .SENSOR_W    (10),
    .DARK_TH     (300),
    .BRIGHT_TH   (600),
    .HOLD_PERIODS(3),
    .FADE_STEP   (256)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .motion      (motion),
    .light_sensor(light_sensor),
    .mode        (mode),
    .led_on      (led_on),
    .pwm_led     (pwm_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  // Measure one whole PWM period: high counts per channel and led_on at its start
  task automatic measure_period(output int h0, output int h1, output logic [1:0] on);
    int guard;
    guard = 0;
    h0 = 0;
    h1 = 0;
    while (((edge_cnt % PERIOD) != 1) && (guard < 3 * PERIOD)) begin
      @(negedge clk);
      guard++;
    end
    if ((edge_cnt % PERIOD) != 1) begin
      n_checks++;
      n_fail++;
      $display("FAIL period_align: edge_cnt=%0d, required phase 1", edge_cnt);
    end
    on = led_on;
    for (int i = 0; i < PERIOD; i++) begin
      if (i != 0) @(negedge clk);
      h0 = h0 + (pwm_led[0] ? 1 : 0);
      h1 = h1 + (pwm_led[1] ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    motion       = 2'b00;
    light_sensor = 10'd0;
    mode         = 4'b0000;
    repeat (3) @(negedge clk);
    n_checks++;
    if (led_on !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_led_on: got %b, expected 00", led_on);
    end
    n_checks++;
    if (pwm_led !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_pwm_led: got %b, expected 00", pwm_led);
    end
    light_sensor = 10'd200;
    mode         = 4'b0101;
    motion       = 2'b01;
    rst          = 1'b1;
  endtask

  task automatic test_dark_ramp();
    int e0[6];
    int d0, d1;
    logic [1:0] on;
    e0 = '{0, 0, 256, 512, 768, 823};
    for (int k = 0; k < 6; k++) begin
      measure_period(d0, d1, on);
      n_checks++;
      if (d0 !== e0[k]) begin n_fail++; $display("FAIL ramp P%0d ch0 duty: got %0d, expected %0d", k, d0, e0[k]); end
      n_checks++;
      if (d1 !== 0) begin n_fail++; $display("FAIL ramp P%0d ch1 duty: got %0d, expected 0", k, d1); end
      n_checks++;
      if (on[0] !== (e0[k] != 0)) begin n_fail++; $display("FAIL ramp P%0d ch0 led_on: got %b, expected %b", k, on[0], e0[k] != 0); end
      n_checks++;
      if (on[1] !== 1'b0) begin n_fail++; $display("FAIL ramp P%0d ch1 led_on: got %b, expected 0", k, on[1]); end
    end
  endtask

  // Hysteresis on ch0 while ch1 receives a single-clock motion pulse
  task automatic test_hysteresis_pulse();
    int e0[20];
    int e1[20];
    int d0, d1;
    logic [1:0] on;
    e0 = '{823, 823, 567, 523, 523, 523, 267, 11, 0, 0,
           0, 0, 0, 0, 0, 0, 256, 512, 768, 773};
    e1 = '{0, 256, 512, 523, 267, 11, 0, 0, 0, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 6; k <= 25; k++) begin
      case (k)
        6: begin
          light_sensor = 10'd500;
          motion[1]    = 1'b1;
          @(negedge clk);
          motion[1]    = 1'b0;
        end
        10: light_sensor = 10'd650;
        15: light_sensor = 10'd500;
        17: light_sensor = 10'd300;
        20: light_sensor = 10'd250;
        default: ;
      endcase
      measure_period(d0, d1, on);
      n_checks++;
      if (d0 !== e0[k-6]) begin n_fail++; $display("FAIL hyst P%0d ch0 duty: got %0d, expected %0d", k, d0, e0[k-6]); end
      n_checks++;
      if (d1 !== e1[k-6]) begin n_fail++; $display("FAIL pulse P%0d ch1 duty: got %0d, expected %0d", k, d1, e1[k-6]); end
      n_checks++;
      if (on[0] !== (e0[k-6] != 0)) begin n_fail++; $display("FAIL hyst P%0d ch0 led_on: got %b, expected %b", k, on[0], e0[k-6] != 0); end
      n_checks++;
      if (on[1] !== (e1[k-6] != 0)) begin n_fail++; $display("FAIL pulse P%0d ch1 led_on: got %b, expected %b", k, on[1], e1[k-6] != 0); end
    end
  endtask

  task automatic test_hold();
    int e0[12];
    int d0, d1;
    logic [1:0] on;
    e0 = '{773, 773, 773, 773, 773, 773, 773, 773, 517, 261, 5, 0};
    for (int k = 26; k <= 37; k++) begin
      case (k)
        26: motion[0] = 1'b0;
        28: motion[0] = 1'b1;
        30: motion[0] = 1'b0;
        default: ;
      endcase
      measure_period(d0, d1, on);
      n_checks++;
      if (d0 !== e0[k-26]) begin n_fail++; $display("FAIL hold P%0d ch0 duty: got %0d, expected %0d", k, d0, e0[k-26]); end
      n_checks++;
      if (d1 !== 0) begin n_fail++; $display("FAIL hold P%0d ch1 duty: got %0d, expected 0", k, d1); end
      n_checks++;
      if (on[0] !== (e0[k-26] != 0)) begin n_fail++; $display("FAIL hold P%0d ch0 led_on: got %b, expected %b", k, on[0], e0[k-26] != 0); end
    end
  endtask

  task automatic test_mode_force();
    int e1[5];
    int d0, d1;
    logic [1:0] on;
    e1 = '{0, 256, 512, 768, 1023};
    for (int k = 38; k <= 42; k++) begin
      if (k == 38) begin
        light_sensor = 10'd900;
        mode         = 4'b1001;
      end
      measure_period(d0, d1, on);
      n_checks++;
      if (d1 !== e1[k-38]) begin n_fail++; $display("FAIL force P%0d ch1 duty: got %0d, expected %0d", k, d1, e1[k-38]); end
      n_checks++;
      if (d0 !== 0) begin n_fail++; $display("FAIL force P%0d ch0 duty: got %0d, expected 0", k, d0); end
      n_checks++;
      if (on[1] !== (e1[k-38] != 0)) begin n_fail++; $display("FAIL force P%0d ch1 led_on: got %b, expected %b", k, on[1], e1[k-38] != 0); end
    end
    // Switch ch1 OFF right after a wrap; prepare ch0 for the extremes test
    mode         = 4'b0001;
    light_sensor = 10'd0;
    motion[0]    = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pwm_led[1] !== 1'b1) begin n_fail++; $display("FAIL off_1clk pwm_led1: got %b, expected 1", pwm_led[1]); end
    @(negedge clk);
    n_checks++;
    if (pwm_led[1] !== 1'b0) begin n_fail++; $display("FAIL off_2clk pwm_led1: got %b, expected 0", pwm_led[1]); end
    n_checks++;
    if (led_on[1] !== 1'b0) begin n_fail++; $display("FAIL off_2clk led_on1: got %b, expected 0", led_on[1]); end
  endtask

  task automatic test_extremes();
    int e0[5];
    int d0, d1;
    logic [1:0] on;
    e0 = '{0, 256, 512, 768, 1023};
    for (int k = 44; k <= 48; k++) begin
      measure_period(d0, d1, on);
      n_checks++;
      if (d0 !== e0[k-44]) begin n_fail++; $display("FAIL light0 P%0d ch0 duty: got %0d, expected %0d", k, d0, e0[k-44]); end
      n_checks++;
      if (d1 !== 0) begin n_fail++; $display("FAIL light0 P%0d ch1 duty: got %0d, expected 0", k, d1); end
    end
  endtask

  task automatic test_reset_midrun();
    int d0, d1;
    logic [1:0] on;
    n_checks++;
    if (led_on[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset led_on0: got %b, expected 1", led_on[0]); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwm_led[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset pwm_led0: got %b, expected 1", pwm_led[0]); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (led_on !== 2'b00) begin n_fail++; $display("FAIL async_reset led_on: got %b, expected 00", led_on); end
    n_checks++;
    if (pwm_led !== 2'b00) begin n_fail++; $display("FAIL async_reset pwm_led: got %b, expected 00", pwm_led); end
    mode = 4'b1001;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // A restarted pwm_cnt puts the first FORCE step exactly in period 1
    measure_period(d0, d1, on);
    n_checks++;
    if (d1 !== 0) begin n_fail++; $display("FAIL restart P0 ch1 duty: got %0d, expected 0", d1); end
    n_checks++;
    if (d0 !== 0) begin n_fail++; $display("FAIL restart P0 ch0 duty: got %0d, expected 0", d0); end
    measure_period(d0, d1, on);
    n_checks++;
    if (d1 !== 256) begin n_fail++; $display("FAIL restart P1 ch1 duty: got %0d, expected 256", d1); end
    n_checks++;
    if (on[1] !== 1'b1) begin n_fail++; $display("FAIL restart P1 ch1 led_on: got %b, expected 1", on[1]); end
    n_checks++;
    if (d0 !== 0) begin n_fail++; $display("FAIL restart P1 ch0 duty: got %0d, expected 0", d0); end
  endtask

  initial begin
    test_reset();
    test_dark_ramp();
    test_hysteresis_pulse();
    test_hold();
    test_mode_force();
    test_extremes();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
